// File: rtl/lsim_gate_if.sv
// lsim_gate_if: signal bundle for one lsim_gate cell.
//   a       : reduction inputs, padded by the driver with the gate's identity value
//   d       : requested propagation delay in clock cycles (0 = combinational)
//   o       : gate output
//   toggles : saturating count of output changes seen at clock edges
// master drives a/d and observes o/toggles; slave is the gate side.
interface lsim_gate_if #(
    parameter int WIDTH   = 32,
    parameter int DELAY_W = 32,
    parameter int CNT_W   = 16
);
    logic [WIDTH-1:0]   a;
    logic [DELAY_W-1:0] d;
    logic               o;
    logic [CNT_W-1:0]   toggles;

    modport master (output a, d, input o, toggles);
    modport slave  (input a, d, output o, toggles);
endinterface

// File: rtl/lsim_gate.sv
// lsim_gate: reduction gate primitive with a programmable clocked delay
// and an output activity counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears history and counter and
//           holds the output low while asserted
//   bus   : lsim_gate_if.slave (a, d in; o, toggles out)
// OP selects AND/OR/NAND/NOR/XOR/XNOR (0..5); any other value acts as AND.
module lsim_gate #(
    parameter int WIDTH     = 32,
    parameter int OP        = 0,
    parameter int MAX_DELAY = 15,
    parameter int DELAY_W   = 32,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    lsim_gate_if.slave  bus
);
    localparam int KW = (MAX_DELAY < 1) ? 1 : $clog2(MAX_DELAY + 1);

    logic                 w_r;
    logic [KW-1:0]        w_k;
    logic [MAX_DELAY:0]   w_tap;
    logic                 w_o;
    logic [MAX_DELAY:1]   r_hist;
    logic                 r_o_prev;
    logic [CNT_W-1:0]     r_cnt;

    always_comb begin
        w_r = &bus.a;
        case (OP)
            1:       w_r = |bus.a;
            2:       w_r = ~&bus.a;
            3:       w_r = ~|bus.a;
            4:       w_r = ^bus.a;
            5:       w_r = ~^bus.a;
            default: w_r = &bus.a;
        endcase
    end

    // Delays beyond the history depth clamp to the deepest tap.
    assign w_k = (bus.d > DELAY_W'(MAX_DELAY)) ? KW'(MAX_DELAY) : bus.d[KW-1:0];

    // Tap 0 is the live reduction, tap i is the value sampled i edges ago,
    // so a delay change simply moves the read point without touching history.
    assign w_tap = {r_hist, w_r};
    assign w_o   = rst_n ? w_tap[w_k] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist   <= '0;
            r_o_prev <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_hist   <= w_tap[MAX_DELAY-1:0];
            r_o_prev <= w_o;
            if ((w_o != r_o_prev) && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.o       = w_o;
    assign bus.toggles = r_cnt;
endmodule

// File: tb/tb_lsim_gate.sv
// tb_lsim_gate: directed checks of AND, OR and XOR flavoured lsim_gate cells.
module tb_lsim_gate;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lsim_gate_if if_and ();
    lsim_gate_if if_or  ();
    lsim_gate_if if_xor ();

    lsim_gate #(.OP(0)) u_and (.clk(clk), .rst_n(rst_n), .bus(if_and));
    lsim_gate #(.OP(1)) u_or  (.clk(clk), .rst_n(rst_n), .bus(if_or));
    lsim_gate #(.OP(4)) u_xor (.clk(clk), .rst_n(rst_n), .bus(if_xor));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        if_and.a = '0; if_and.d = '0;
        if_or.a  = '0; if_or.d  = '0;
        if_xor.a = '0; if_xor.d = '0;
        #1;
        chk("rst_and_o", 32'(if_and.o), 32'd0);
        chk("rst_and_tog", 32'(if_and.toggles), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // AND, combinational
        if_and.a = 32'hFFFF_FFFF; #1;
        chk("and_d0_ones", 32'(if_and.o), 32'd1);
        if_and.a = 32'hFFFF_FFFD; #1;
        chk("and_d0_one_zero", 32'(if_and.o), 32'd0);

        // OR, combinational, and the toggle counter
        if_or.a = 32'h0; #1;
        chk("or_d0_zero", 32'(if_or.o), 32'd0);
        chk("or_tog_init", 32'(if_or.toggles), 32'd0);
        if_or.a = 32'h2; #1;
        chk("or_d0_bit1", 32'(if_or.o), 32'd1);
        chk("or_tog_before_edge", 32'(if_or.toggles), 32'd0);
        tick(1);
        chk("or_tog_after_edge", 32'(if_or.toggles), 32'd1);

        // AND with d=3
        if_and.a = 32'h0; if_and.d = 32'd3;
        tick(16);
        if_and.a = 32'hFFFF_FFFF; #1;
        chk("and_d3_e0", 32'(if_and.o), 32'd0);
        tick(1);
        chk("and_d3_e1", 32'(if_and.o), 32'd0);
        tick(1);
        chk("and_d3_e2", 32'(if_and.o), 32'd0);
        tick(1);
        chk("and_d3_e3", 32'(if_and.o), 32'd1);

        // d=100 clamps to 15
        if_and.a = 32'h0; if_and.d = 32'd100;
        tick(16);
        if_and.a = 32'hFFFF_FFFF;
        tick(14);
        chk("and_d100_e14", 32'(if_and.o), 32'd0);
        tick(1);
        chk("and_d100_e15", 32'(if_and.o), 32'd1);
        if_and.a = 32'hFFFF_FFFD; if_and.d = 32'd15; #1;
        chk("and_d15_hist", 32'(if_and.o), 32'd1);
        if_and.d = 32'd0; #1;
        chk("and_d15_to_0", 32'(if_and.o), 32'd0);

        // Asynchronous reset mid-cycle with o=1
        if_and.a = 32'hFFFF_FFFF; #1;
        chk("and_pre_rst", 32'(if_and.o), 32'd1);
        tick(2);
        #1;
        rst_n = 1'b0; #1;
        chk("async_rst_o", 32'(if_and.o), 32'd0);
        chk("async_rst_tog", 32'(if_and.toggles), 32'd0);
        if_and.d = 32'd2;
        tick(1);
        #2;
        rst_n = 1'b1; #1;
        chk("rel_d2_e0", 32'(if_and.o), 32'd0);
        tick(1);
        chk("rel_d2_e1", 32'(if_and.o), 32'd0);
        tick(1);
        chk("rel_d2_e2", 32'(if_and.o), 32'd1);
        chk("rel_tog_e2", 32'(if_and.toggles), 32'd0);
        tick(1);
        chk("rel_tog_e3", 32'(if_and.toggles), 32'd1);

        // XOR parity
        if_xor.a = 32'h7; #1;
        chk("xor_odd", 32'(if_xor.o), 32'd1);
        if_xor.a = 32'h3; #1;
        chk("xor_even", 32'(if_xor.o), 32'd0);
        chk("xor_tog_init", 32'(if_xor.toggles), 32'd0);

        // Toggle every cycle to saturate the 16-bit counter
        for (int i = 0; i < 70000; i++) begin
            if_xor.a = (i % 2 == 0) ? 32'h7 : 32'h3;
            tick(1);
            if (i == 99) chk("xor_tog_100", 32'(if_xor.toggles), 32'd100);
        end
        chk("xor_tog_sat", 32'(if_xor.toggles), 32'hFFFF);
        if_xor.a = 32'h7;
        tick(1);
        chk("xor_tog_no_wrap", 32'(if_xor.toggles), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lsim_gate.md
Name: lsim_gate

Overview:
- Configurable reduction logic gate with programmable clocked propagation delay, used as the primitive cell of the gate-level simulation netlist.
- AND cells present unused input bits as 1 and OR cells present them as 0, so a wide padded vector reduces correctly.
- One cell type implements both the AND flavour (andgate role) and the OR flavour (orgate role), selected by parameter.
- Also counts output transitions for activity reporting.

Parameters:
- WIDTH, 32, input vector width.
- OP, 0, reduction function: 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR; other values behave as AND.
- MAX_DELAY, 15, deepest supported delay in clock cycles (history depth).
- DELAY_W, 32, width of the delay input port.
- CNT_W, 16, width of the transition counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  gate inputs; caller pads unused bits with the function's identity value.
- d  input  DELAY_W  propagation delay in clock cycles; 0 means combinational.
- o  output  1  gate output.
- toggles  output  CNT_W  count of observed changes of o.

Behaviour:
- r = reduction of all WIDTH bits of a per OP, e.g. AND: r=1 iff all bits 1; OR: r=1 iff any bit 1; XOR: odd parity.
- Effective delay k = min(d, MAX_DELAY); d is unsigned.
- History register h[1..MAX_DELAY]:
  - Each rising edge: h[1]<=r and h[i]<=h[i-1].
  - Always recorded regardless of d.
- o selection:
  - k=0: o=r, purely combinational.
  - k>0: o=h[k], i.e. r as sampled k rising edges earlier.
- d change mid-operation: new tap takes effect immediately, combinationally; history is not flushed.
- Reset (rst_n low):
  - Asynchronously clears all h to 0 and toggles to 0.
  - o forced to 0 for every k while rst_n is low.
- After reset release with k>0: o=0 until k edges have occurred, then tracks r delayed.
- toggles:
  - Register o_prev sampled each edge; reset value 0.
  - When rst_n is high and o != o_prev at an edge, toggles increments.
  - Saturates at all-ones, no wrap.
- No X propagation requirements beyond standard 2-state behaviour.
- No handshake.

Test Plan:
- OP=0, d=0, a=32'hFFFFFFFC+2'b11 (=all ones) -> o=1 same cycle; a=32'hFFFFFFFC+2'b01 -> o=0 immediately.
- OP=1, d=0, a=32'h0+2'b00 -> o=0; a=2'b10 -> o=1; toggles increments by 1 on the next edge.
- OP=0, d=3, a switched to all-ones after reset -> o stays 0 for edges 1-2 after the change, becomes 1 after the 3rd edge.
- d=100 with MAX_DELAY=15 -> behaves exactly as d=15; switch d 15->0 mid-run -> o equals current r immediately.
- Assert rst_n=0 mid-run with o=1, between clock edges -> o=0 and toggles=0 immediately, without waiting for an edge; release with d=2 -> o=0 for 2 edges.
- OP=4, a=32'h00000007 -> o=1; a=32'h00000003 -> o=0. Drive 70000 toggles with CNT_W=16 -> toggles holds 16'hFFFF.
